// File: rtl/mul_ucode_seq.sv
// mul_ucode_seq: microcode sequencer for the MUL instruction.
// Watches the fetched instruction stream next to iFetch. On MUL it pulses
// mul_trigger, which freezes the PC. It then issues CLR, STEPS x STEP and WB
// shift-add micro-ops under a valid/ready handshake. Finally it pulses
// mul_release so that iFetch resumes filtering.
// Optional feature macro: MUL_EARLY_EXIT_EN. When it is defined, a STEP
// handshake with mplier_zero=1 jumps straight to WB.
module mul_ucode_seq #(
  parameter int         STEPS      = 16,
  parameter logic [6:0] MUL_OPCODE = 7'b0010010,
  parameter logic [6:0] UOP_OPCODE = 7'b1110000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        flush,
  input  logic        uop_ready,
  input  logic        mplier_zero,
  output logic        mul_trigger,
  output logic        mul_release,
  output logic        uop_valid,
  output logic [31:0] uop_instr,
  output logic        busy
);

  localparam int CW = $clog2(STEPS);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_CLR, S_STEP, S_WB, S_REL
  } state_t;

  typedef enum logic [1:0] {
    SUB_CLR  = 2'b00,
    SUB_STEP = 2'b01,
    SUB_WB   = 2'b10
  } sub_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    rd_q, rs1_q, rs2_q;

  logic last_step;
  logic exit_now;
  logic is_mul;

  assign is_mul    = instr_valid && (instr[31:25] == MUL_OPCODE);
  assign last_step = (cnt == CW'(STEPS - 1));

`ifdef MUL_EARLY_EXIT_EN
  assign exit_now = last_step || mplier_zero;
`else
  logic unused_mplier_zero;
  assign unused_mplier_zero = mplier_zero;
  assign exit_now           = last_step;
`endif

  logic unused_instr_low;
  assign unused_instr_low = ^instr[12:0];

  // Sequencer state, step counter and latched register specifiers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and the simulation order of the
  // blocks cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mul) begin
            rd_q  <= instr[24:21];
            rs1_q <= instr[20:17];
            rs2_q <= instr[16:13];
            state <= S_TRIG;
          end
        end
        S_TRIG: state <= flush ? S_REL : S_CLR;
        S_CLR: begin
          if (flush) begin
            state <= S_REL;
          end else if (uop_ready) begin
            cnt   <= '0;
            state <= S_STEP;
          end
        end
        S_STEP: begin
          if (flush) begin
            state <= S_REL;
          end else if (uop_ready) begin
            if (exit_now) state <= S_WB;
            else          cnt   <= cnt + 1'b1;
          end
        end
        S_WB: begin
          if (flush || uop_ready) state <= S_REL;
        end
        S_REL: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic uop_active;
  sub_t sub;
  logic [4:0] step_field;

  // Output decode from registered state. Only flush reaches an output
  // combinationally, which lets a flush cancel the uop in its own cycle.
  // NOTE: every signal here gets a value on every path, so no latch is inferred.
  always_comb begin
    uop_active = 1'b0;
    sub        = SUB_CLR;
    step_field = '0;
    case (state)
      S_CLR:  begin uop_active = 1'b1; sub = SUB_CLR; end
      S_STEP: begin uop_active = 1'b1; sub = SUB_STEP; step_field = 5'(cnt); end
      S_WB:   begin uop_active = 1'b1; sub = SUB_WB; end
      default: ;
    endcase
  end

  assign mul_trigger = (state == S_TRIG);
  assign mul_release = (state == S_REL);
  assign busy        = (state != S_IDLE);
  assign uop_valid   = uop_active && !flush;
  assign uop_instr   = uop_active
                     ? {UOP_OPCODE, rd_q, rs1_q, rs2_q, sub, step_field, 6'b0}
                     : 32'b0;

endmodule

// File: tb/tb_mul_ucode_seq.sv
// tb_mul_ucode_seq: randomized self-checking bench for mul_ucode_seq.
// The reference model is a queue holding the expected micro-ops of one MUL.
// A handshake pops the queue, a flush empties it, and a release is expected
// in the cycle after the queue is empty.
module tb_mul_ucode_seq;

  localparam int         STEPS = 16;
  localparam logic [6:0] MUL_OP = 7'b0010010;
  localparam logic [6:0] UOP_OP = 7'b1110000;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        flush;
  logic        uop_ready;
  logic        mplier_zero;
  logic        mul_trigger;
  logic        mul_release;
  logic        uop_valid;
  logic [31:0] uop_instr;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  mul_ucode_seq #(.STEPS(STEPS), .MUL_OPCODE(MUL_OP), .UOP_OPCODE(UOP_OP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .flush       (flush),
    .uop_ready   (uop_ready),
    .mplier_zero (mplier_zero),
    .mul_trigger (mul_trigger),
    .mul_release (mul_release),
    .uop_valid   (uop_valid),
    .uop_instr   (uop_instr),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_uop(input logic [3:0] rd, input logic [3:0] rs1,
                                         input logic [3:0] rs2, input logic [1:0] sub,
                                         input logic [4:0] step);
    return {UOP_OP, rd, rs1, rs2, sub, step, 6'b0};
  endfunction

  task automatic idle_inputs();
    instr       = 32'h0;
    instr_valid = 1'b0;
    flush       = 1'b0;
    uop_ready   = 1'b0;
    mplier_zero = 1'b0;
  endtask

  // One complete MUL transaction, checked cycle by cycle against the queue model.
  //   ready_pct  : probability (in percent) that uop_ready is high
  //   flush_at   : handshake index at which flush is raised (-1 means never)
  //   zero_at    : STEP index whose handshake sees mplier_zero=1 (-1 means never)
  //   stall_at   : STEP index that is refused 3 extra times (-1 means never)
  task automatic run_mul(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                         input int ready_pct, input int flush_at, input int zero_at,
                         input int stall_at);
    logic [31:0] q[$];
    logic [31:0] front;
    int  cycles, hs, forced, skipped;
    bit  flushed, done;
    q.push_back(mk_uop(rd, rs1, rs2, 2'b00, 5'd0));
    for (int s = 0; s < STEPS; s++) q.push_back(mk_uop(rd, rs1, rs2, 2'b01, 5'(s)));
    q.push_back(mk_uop(rd, rs1, rs2, 2'b10, 5'd0));
    cycles = 0; hs = 0; forced = 0; skipped = 0; flushed = 1'b0; done = 1'b0;

    // T0: present the MUL.
    @(negedge clk);
    idle_inputs();
    instr       = {MUL_OP, rd, rs1, rs2, 13'($urandom)};
    instr_valid = 1'b1;
    #1;
    check("t0_busy", busy, 1'b0);
    check("t0_trig", mul_trigger, 1'b0);

    // T1: trigger. Offer a second MUL with different fields; it must be ignored.
    @(negedge clk);
    instr = {MUL_OP, ~rd, ~rs1, ~rs2, 13'h0};
    instr_valid = 1'b1;
    #1;
    check("t1_trig", mul_trigger, 1'b1);
    check("t1_valid", uop_valid, 1'b0);
    check("t1_busy", busy, 1'b1);

    while (!done && cycles < 300) begin
      @(negedge clk);
      cycles++;
      instr_valid = $urandom_range(1);
      if (q.size() > 0 && !flushed) begin
        front     = q[0];
        uop_ready = ($urandom_range(99) < ready_pct);
        if (front[12:11] == 2'b01 && int'(front[10:6]) == stall_at && forced < 3) begin
          uop_ready = 1'b0;
          forced++;
        end
        flush = (hs == flush_at);
        if (front[12:11] == 2'b01) mplier_zero = (int'(front[10:6]) == zero_at);
        else                       mplier_zero = $urandom_range(1);
        #1;
        check("trig_low", mul_trigger, 1'b0);
        check("rel_low", mul_release, 1'b0);
        check("uop_valid", uop_valid, !flush);
        if (flush) begin
          flushed = 1'b1;
        end else begin
          check("uop_instr", uop_instr, front);
          if (uop_ready) begin
            hs++;
            void'(q.pop_front());
`ifdef MUL_EARLY_EXIT_EN
            if (front[12:11] == 2'b01 && mplier_zero) begin
              while (q.size() > 1) begin
                void'(q.pop_front());
                skipped++;
              end
            end
`endif
          end
        end
      end else begin
        // Release cycle. A flush or a MUL seen here must have no effect.
        flush       = $urandom_range(1);
        uop_ready   = $urandom_range(1);
        instr       = {MUL_OP, 25'($urandom)};
        instr_valid = 1'b1;
        #1;
        check("release", mul_release, 1'b1);
        check("rel_valid", uop_valid, 1'b0);
        check("rel_busy", busy, 1'b1);
        if (ready_pct == 100 && flush_at < 0)
          check("rel_time", 1 + cycles, 4 + STEPS + forced - skipped);
        done = 1'b1;
      end
    end
    if (!done) check("timeout", 1'b0, 1'b1);

    @(negedge clk);
    idle_inputs();
    #1;
    check("idle_busy", busy, 1'b0);
    check("idle_rel", mul_release, 1'b0);
    @(negedge clk);
    #1;
    check("no_retrig", mul_trigger, 1'b0);
    check("still_idle", busy, 1'b0);
  endtask

  initial begin
    bit found;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_uop", uop_instr, 32'h0);
    check("rst_valid", uop_valid, 1'b0);
    rst_n = 1'b1;

    // A non-MUL opcode and a flush in IDLE must both be ignored.
    repeat (3) begin
      @(negedge clk);
      instr       = {7'b1100000, 25'($urandom)};
      instr_valid = 1'b1;
      flush       = 1'b1;
      #1;
      check("nonmul_trig", mul_trigger, 1'b0);
      check("nonmul_busy", busy, 1'b0);
    end
    @(negedge clk);
    idle_inputs();

    // Basic, backpressure, flush and early-exit cases.
    run_mul(4'd3, 4'd1, 4'd2, 100, -1, -1, -1);
    run_mul(4'd9, 4'd4, 4'd7, 100, -1, -1, 4);
    run_mul(4'd6, 4'd5, 4'd8, 100, 8, -1, -1);   // flush while in STEP 7
    run_mul(4'd1, 4'd2, 4'd3, 100, -1, 2, -1);   // mplier_zero on STEP 2
    run_mul(4'd2, 4'd2, 4'd2, 100, 0, -1, -1);   // flush in CLR
    run_mul(4'd7, 4'd0, 4'd15, 100, STEPS + 1, -1, -1); // flush in WB

    // Randomized transactions.
    for (int i = 0; i < 25; i++) begin
      run_mul(4'($urandom), 4'($urandom), 4'($urandom),
              $urandom_range(100, 30),
              ($urandom_range(3) == 0) ? int'($urandom_range(STEPS + 1)) : -1,
              ($urandom_range(2) == 0) ? int'($urandom_range(STEPS - 1)) : -1,
              ($urandom_range(3) == 0) ? int'($urandom_range(STEPS - 1)) : -1);
    end

    // Async reset in the middle of STEP 5.
    @(negedge clk);
    idle_inputs();
    instr       = {MUL_OP, 4'd5, 4'd6, 4'd7, 13'h0};
    instr_valid = 1'b1;
    uop_ready   = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      #1;
      found = uop_valid && (uop_instr == mk_uop(4'd5, 4'd6, 4'd7, 2'b01, 5'd5));
    end
    check("reach_step5", found, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_trig", mul_trigger, 1'b0);
    check("arst_rel", mul_release, 1'b0);
    check("arst_valid", uop_valid, 1'b0);
    check("arst_uop", uop_instr, 32'h0);
    check("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    repeat (4) begin
      @(negedge clk);
      #1;
      check("post_rst_rel", mul_release, 1'b0);
      check("post_rst_busy", busy, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
